// File: rtl/riscv_pkg.sv
// riscv_pkg: shared pipeline widths and writeback result-select encoding.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_e;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register storage, async clear, one sync write port, two raw combinational reads.
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback result select, register file commit with write-through bypass, x0 masking.
module wb_regfile #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [4:0]      RdW,
    input  logic [4:0]      A1D,
    input  logic [4:0]      A2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic            IllegalSrcW
);

    import riscv_pkg::*;

    result_src_e     src;
    logic            commit;
    logic            rsvd_write;
    logic [XLEN-1:0] raw1;
    logic [XLEN-1:0] raw2;

    assign src = result_src_e'(ResultSrcW);

    always_comb begin
        ResultW = src == RES_ALU ? ALUResultW :
                  src == RES_MEM ? ReadDataW  :
                  src == RES_PC4 ? PCPlus4W   : '0;
    end

    // Commit qualifier deliberately excludes ResultW so the bypass select settles off the short path.
    assign rsvd_write = RegWriteW && src == RES_RSVD;
    assign commit     = RegWriteW && !reset && RdW != '0 && src != RES_RSVD;

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (5)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (commit),
        .wa    (RdW),
        .wd    (ResultW),
        .ra1   (A1D),
        .ra2   (A2D),
        .rd1   (raw1),
        .rd2   (raw2)
    );

    always_comb begin
        RD1D = A1D == '0                  ? '0      :
               (commit && A1D == RdW)     ? ResultW : raw1;
        RD2D = A2D == '0                  ? '0      :
               (commit && A2D == RdW)     ? ResultW : raw2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) IllegalSrcW <= 1'b0;
        else if (rsvd_write) IllegalSrcW <= 1'b1;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file of the five-stage pipeline. Consumes the MEM/WB register outputs and selects the writeback result. Commits that result to a 32×32 register file and serves the two decode-stage read ports. Exports the selected result to the forwarding unit.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count (address width = $clog2(NREGS) = 5)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- RegWriteW  in  1  write enable from MEM/WB
- ResultSrcW  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved
- ALUResultW  in  XLEN  ALU result
- ReadDataW  in  XLEN  load data
- PCPlus4W  in  XLEN  link address
- RdW  in  5  destination register
- A1D  in  5  decode read address, port 1
- A2D  in  5  decode read address, port 2
- RD1D  out  XLEN  read data, port 1
- RD2D  out  XLEN  read data, port 2
- ResultW  out  XLEN  selected writeback value, to forwarding mux
- IllegalSrcW  out  1  sticky flag: reserved ResultSrcW seen with RegWriteW=1

## Operation
- Result mux (combinational):
  - ResultSrcW=00 gives ALUResultW.
  - 01 gives ReadDataW.
  - 10 gives PCPlus4W.
  - 11 gives 0.
- Commit: the write is effective when RegWriteW=1, RdW≠0 and ResultSrcW≠11. It stores ResultW into rf[RdW] at the rising clk edge.
- x0: rf[0] is never written. Reads of address 0 always return 0.
- Reads are combinational, with write-through bypass:
  - If the address is 0, the output is 0.
  - Otherwise, if a commit is effective this cycle and the address equals RdW, the output is ResultW.
  - Otherwise the output is rf[address].
- Both read ports are independent. A1D=A2D=RdW returns ResultW on both.
- Reserved select:
  - No register is modified.
  - IllegalSrcW sets at the next edge and stays set until reset.
  - The write is treated as non-effective for the bypass as well.
- RegWriteW=0: no state change regardless of the other inputs. The bypass is inactive.

## Timing
- Reset (asynchronous assert, synchronous release) has these effects:
  - rf[1..31] clear to 0 immediately.
  - IllegalSrcW clears to 0.
  - RD1D, RD2D and ResultW follow their combinational definitions. With the upstream MEM/WB register also in reset, all three read 0.
- While reset is high, no commit occurs even if RegWriteW=1.
- Reset asserted mid-operation discards any write pending at that edge. All registers read 0 afterwards.
- Write latency: a value is visible on the read ports in the same cycle through the bypass. From the next cycle it is visible from storage.
- No stall or flush inputs. MEM/WB bubbles arrive as RegWriteW=0.
- Critical path: ResultSrcW → result mux → bypass compare/mux → RD1D/RD2D, which feeds the ID/EX register. Keep the bypass compare on RdW and RegWriteW only, not on ResultW.

## Structure
- Shared package riscv_pkg holds:
  - XLEN and REG_AW=5.
  - enum result_src_e {RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_RSVD=2'b11}.
- The block instantiates one sub-module, regfile_2r1w. It holds the storage array with async reset, one synchronous write port and two raw combinational read ports.
- Result mux, x0 masking, bypass and the illegal flag live in wb_regfile.

## Test plan
- Reset: hold reset, then release. Require:
  - RD1D=RD2D=0 for all A1D/A2D in 0..31.
  - IllegalSrcW=0.
- ALU write with bypass: RegWriteW=1, ResultSrcW=00, ALUResultW=0x0000_1234, RdW=5, A1D=5. Require:
  - RD1D=0x1234 in the same cycle.
  - Next cycle, with RegWriteW=0, RD1D=0x1234.
- Source select: write x7 with ResultSrcW=01 / ReadDataW=0xDEAD_BEEF, then x8 with 10 / PCPlus4W=0x0000_0104. Require x7=0xDEADBEEF and x8=0x104 on both read ports.
- x0 protection: RegWriteW=1, RdW=0, ALUResultW=0xFFFF_FFFF, A1D=A2D=0. Require:
  - RD1D=RD2D=0 in the same cycle.
  - RD1D=RD2D=0 in every later cycle.
- Reserved select: preload x3=0x55. Apply RegWriteW=1, ResultSrcW=11, RdW=3, A1D=3. Require:
  - ResultW=0.
  - RD1D=0x55 (no bypass).
  - x3 stays 0x55.
  - IllegalSrcW=1 after the edge and stays 1 until reset.
- Reset mid-write: x9=0xA5A5_A5A5. Assert reset between edges while RegWriteW=1, RdW=9, ALUResultW=0x1. Require x9=0 immediately and after release.
